mul_share_arb: RTL and testbench

MUL_SHARE_ARB -- requirements
Module: mul_share_arb

---
 rtl/mul_share_arb_pkg.sv | 23 ++
 rtl/mul_share_arb_mul.sv | 33 +++
 rtl/mul_share_arb.sv | 107 ++++++++++
 tb/tb_mul_share_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_arb_pkg.sv
// Shared widths and pipeline entry types for the shared-multiplier arbiter.
package mul_share_arb_pkg;

  localparam int PKG_NREQ = 4;
  localparam int PKG_A_W  = 27;
  localparam int PKG_B_W  = 18;
  localparam int PKG_P_W  = PKG_A_W + PKG_B_W;
  localparam int PKG_ID_W = $clog2(PKG_NREQ);

  typedef struct packed {
    logic                       valid;
    logic [PKG_ID_W-1:0]        id;
    logic signed [PKG_A_W-1:0]  a;
    logic signed [PKG_B_W-1:0]  b;
  } s1_entry_t;

  typedef struct packed {
    logic                       valid;
    logic [PKG_ID_W-1:0]        id;
    logic signed [PKG_P_W-1:0]  p;
  } s2_entry_t;

endpackage

// File: rtl/mul_share_arb_mul.sv
// Combinational signed multiply built from an unsigned-lo / signed-hi split of b.
module mul_split_27x18
  import mul_share_arb_pkg::*;
#(
  parameter int A_W = PKG_A_W,
  parameter int B_W = PKG_B_W,
  parameter int P_W = PKG_P_W
) (
  input  logic signed [A_W-1:0] a_i,
  input  logic signed [B_W-1:0] b_i,
  output logic signed [P_W-1:0] p_o
);

  localparam int H    = B_W / 2;
  localparam int LO_W = A_W + H + 1;
  localparam int HI_W = A_W + H;

  logic signed [LO_W-1:0] a_lo, b_lo, lo;
  logic signed [HI_W-1:0] a_hi, b_hi, hi;

  // Operands are pre-extended to the partial width so each product is exact.
  assign a_lo = {{(H+1){a_i[A_W-1]}}, a_i};
  assign b_lo = {{(A_W+1){1'b0}}, b_i[H-1:0]};
  assign a_hi = {{H{a_i[A_W-1]}}, a_i};
  assign b_hi = {{A_W{b_i[B_W-1]}}, b_i[B_W-1:H]};

  assign lo = a_lo * b_lo;
  assign hi = a_hi * b_hi;

  assign p_o = {{(P_W-LO_W){lo[LO_W-1]}}, lo}
             + ({{(P_W-HI_W){hi[HI_W-1]}}, hi} << H);

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter feeding one two-stage shared multiplier pipeline.
module mul_share_arb
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ = PKG_NREQ,
  parameter int A_W  = PKG_A_W,
  parameter int B_W  = PKG_B_W,
  parameter int P_W  = A_W + B_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*A_W-1:0]        req_a,
  input  logic [NREQ*B_W-1:0]        req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NREQ)-1:0]    res_id,
  output logic [P_W-1:0]             res_p,
  output logic                       busy
);

  localparam int ID_W = $clog2(NREQ);

  s1_entry_t s1_q, s1_d;
  s2_entry_t s2_q, s2_d;

  logic [ID_W-1:0]        last_grant_q, last_grant_d;
  logic [ID_W-1:0]        grant_idx;
  logic                   grant_any;
  logic                   advance;
  logic signed [A_W-1:0]  a_sel;
  logic signed [B_W-1:0]  b_sel;
  logic signed [P_W-1:0]  prod;

  assign advance = !s2_q.valid || res_ready;

  // First requester after last_grant, wrapping, wins.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    grant_any = 1'b0;
    grant_idx = last_grant_q;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx  = (int'(last_grant_q) + k) % NREQ;
      cand = ID_W'(idx);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && grant_any && advance) req_ready[grant_idx] = 1'b1;
  end

  assign a_sel = req_a[grant_idx*A_W +: A_W];
  assign b_sel = req_b[grant_idx*B_W +: B_W];

  mul_split_27x18 #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_mul (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (prod)
  );

  always_comb begin
    s1_d         = s1_q;
    s2_d         = s2_q;
    last_grant_d = last_grant_q;
    if (advance) begin
      s1_d.valid = grant_any;
      s1_d.id    = grant_idx;
      s1_d.a     = a_sel;
      s1_d.b     = b_sel;
      s2_d.valid = s1_q.valid;
      s2_d.id    = s1_q.id;
      s2_d.p     = prod;
      if (grant_any) last_grant_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      last_grant_q <= ID_W'(NREQ - 1);
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_valid = s2_q.valid;
  assign res_id    = s2_q.id;
  assign res_p     = s2_q.p;
  assign busy      = s1_q.valid || s2_q.valid;

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized and directed checks of mul_share_arb against a transaction-level model.
module tb_mul_share_arb;

  localparam int NREQ = 4;
  localparam int A_W  = 27;
  localparam int B_W  = 18;
  localparam int P_W  = A_W + B_W;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*A_W-1:0]   req_a;
  logic [NREQ*B_W-1:0]   req_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [1:0]            res_id;
  logic [P_W-1:0]        res_p;
  logic                  busy;

  always #5 clk = ~clk;

  mul_share_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Requester side: each requester holds its operands until granted.
  logic                  pend [NREQ];
  logic signed [A_W-1:0] pa   [NREQ];
  logic signed [B_W-1:0] pb   [NREQ];
  int                    waitc[NREQ];
  logic                  rr;

  typedef struct {
    bit     v;
    int     id;
    longint p;
  } ent_t;

  ent_t m1, m2;
  int   m_last;
  ent_t sb[$];
  int   grants[$];
  int   drained;
  int   total_hs;

  function automatic longint mul_ref(input logic signed [A_W-1:0] a,
                                     input logic signed [B_W-1:0] b);
    return longint'(a) * longint'(b);
  endfunction

  function automatic logic signed [A_W-1:0] rand_a();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(A_W-1){1'b0}}};
      1:       return {1'b0, {(A_W-1){1'b1}}};
      2:       return '1;
      default: return A_W'($urandom);
    endcase
  endfunction

  function automatic logic signed [B_W-1:0] rand_b();
    case ($urandom_range(0, 7))
      0:       return {1'b1, {(B_W-1){1'b0}}};
      1:       return {1'b0, {(B_W-1){1'b1}}};
      2:       return B_W'(511);
      default: return B_W'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m1.v = 0; m1.id = 0; m1.p = 0;
    m2.v = 0; m2.id = 0; m2.p = 0;
    m_last = NREQ - 1;
    sb.delete();
    for (int i = 0; i < NREQ; i++) waitc[i] = 0;
  endtask

  task automatic arm(input int i);
    pend[i] = 1'b1;
    pa[i]   = rand_a();
    pb[i]   = rand_b();
  endtask

  task automatic cycle();
    int              g;
    bit              adv;
    logic [NREQ-1:0] exp_rdy;
    ent_t            h;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]           = pend[i];
      req_a[i*A_W +: A_W]    = pa[i];
      req_b[i*B_W +: B_W]    = pb[i];
    end
    res_ready = rr;
    #1;
    adv = !m2.v || rr;
    g   = -1;
    if (adv) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", req_ready, exp_rdy);
    check_eq("res_valid", res_valid, m2.v);
    check_eq("busy", busy, m1.v || m2.v);
    if (m2.v) begin
      check_eq("res_id", res_id, m2.id);
      check_eq("res_p", $signed(res_p), m2.p);
    end
    if (m2.v && rr) begin
      check_eq("sb_nonempty", sb.size() > 0, 1'b1);
      if (sb.size() > 0) begin
        h = sb.pop_front();
        check_eq("sb_id", res_id, h.id);
        check_eq("sb_p", $signed(res_p), h.p);
      end
      drained++;
    end
    @(posedge clk);
    if (adv) begin
      m2   = m1;
      m1.v = 0;
      if (g >= 0) begin
        m1.v  = 1;
        m1.id = g;
        m1.p  = mul_ref(pa[g], pb[g]);
        sb.push_back(m1);
        grants.push_back(g);
        m_last = g;
        check_eq("starve", waitc[g] <= NREQ - 1, 1'b1);
        waitc[g] = 0;
        for (int i = 0; i < NREQ; i++) if (i != g && pend[i]) waitc[i]++;
        pend[g] = 1'b0;
        total_hs++;
      end
    end
  endtask

  // Asynchronous reset pulse asserted and released mid-way through a high phase.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq({tag, "_res_valid"}, res_valid, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_req_ready"}, req_ready, 4'b0000);
    check_eq({tag, "_res_p"}, $signed(res_p), 0);
    check_eq({tag, "_res_id"}, res_id, 0);
    model_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    drained  = 0;
    total_hs = 0;
    rr       = 1'b1;
    reset_n  = 1'b0;
    for (int i = 0; i < NREQ; i++) arm(i);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]        = 1'b1;
      req_a[i*A_W +: A_W] = pa[i];
      req_b[i*B_W +: B_W] = pb[i];
    end
    res_ready = 1'b1;
    #3;
    check_eq("rst_res_valid", res_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req_ready", req_ready, 4'b0000);
    check_eq("rst_res_p", $signed(res_p), 0);
    check_eq("rst_res_id", res_id, 0);
    model_reset();
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;

    // Single small product.
    pend[0] = 1'b1; pa[0] = 27'sd3; pb[0] = -18'sd5;
    cycle();
    cycle();
    #1;
    check_eq("d033_valid", res_valid, 1'b1);
    check_eq("d033_id", res_id, 0);
    check_eq("d033_p", $signed(res_p), -15);
    cycle();
    cycle();

    // Extreme corner and unsigned low half.
    pend[0] = 1'b1; pa[0] = {1'b1, 26'd0}; pb[0] = {1'b1, 17'd0};
    cycle();
    pend[0] = 1'b1; pa[0] = '1; pb[0] = 18'sd511;
    cycle();
    #1;
    check_eq("d034_minmin", $signed(res_p), 64'sd1 << 43);
    cycle();
    #1;
    check_eq("d034_lo_unsigned", $signed(res_p), -511);
    cycle();
    cycle();

    // All requesting after reset: strict rotation starting at 0.
    reset_pulse("d035_rst");
    grants.delete();
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) arm(i);
      cycle();
    end
    check_eq("d035_count", grants.size(), 8);
    for (int k = 0; k < 8 && k < grants.size(); k++)
      check_eq($sformatf("d035_grant%0d", k), grants[k], k % NREQ);

    // Backpressure with a full pipeline, then drain without new requests.
    rr = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) arm(i);
      cycle();
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    rr      = 1'b1;
    drained = 0;
    for (int c = 0; c < 6; c++) cycle();
    check_eq("d036_drained", drained, 2);
    check_eq("d036_sb_empty", sb.size(), 0);

    // Reset with both stages occupied discards them; first grant returns to 0.
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) arm(i);
      cycle();
    end
    reset_pulse("d037_rst");
    grants.delete();
    for (int i = 0; i < NREQ; i++) if (!pend[i]) arm(i);
    cycle();
    check_eq("d037_grant_cnt", grants.size(), 1);
    if (grants.size() > 0) check_eq("d037_first_grant", grants[0], 0);
    for (int c = 0; c < 3; c++) cycle();

    // Random traffic with random backpressure.
    total_hs = 0;
    for (int c = 0; c < 40000 && total_hs < 10000; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) arm(i);
      rr = ($urandom_range(0, 3) != 0);
      cycle();
    end
    check_eq("rand_hs_reached", total_hs >= 10000, 1'b1);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    rr = 1'b1;
    for (int c = 0; c < 4; c++) cycle();
    check_eq("final_sb_empty", sb.size(), 0);
    check_eq("final_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
